// File: rtl/sr_flop_pkg.sv
// Shared definitions for the set/reset flop bank: S=R=1 response encodings
// and the per-channel next-state rule.
package sr_flop_pkg;

    typedef enum logic [1:0] {
        SR_SET_DOM = 2'd0,
        SR_RST_DOM = 2'd1,
        SR_HOLD    = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    function automatic logic sr_next_q(input logic fs, input logic fr,
                                       input logic q, input sr_mode_e mode);
        logic nxt;
        nxt = q;
        unique case ({fs, fr})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nxt = 1'b1;
                    SR_RST_DOM: nxt = 1'b0;
                    SR_HOLD:    nxt = q;
                    default:    nxt = ~q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_flop_chan.sv
// One set/reset storage channel: input synchroniser, optional debounce
// filter, registered q/nq and sticky S=R=1 error flag.
module sr_flop_chan
    import sr_flop_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 0,
    parameter sr_mode_e    MODE        = SR_SET_DOM,
    parameter logic        INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    input  logic err_clr,
    output logic q,
    output logic nq,
    output logic err
);

    logic       ss, sr;
    logic [1:0] pair;
    logic [1:0] filt_q, filt_d;
    logic       q_q, q_d, nq_q, err_q, err_d;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign ss = s;
        assign sr = r;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] s_sync_q, r_sync_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_sync_q <= '0;
                r_sync_q <= '0;
            end else begin
                s_sync_q <= SYNC_STAGES'({s_sync_q, s});
                r_sync_q <= SYNC_STAGES'({r_sync_q, r});
            end
        end
        assign ss = s_sync_q[SYNC_STAGES-1];
        assign sr = r_sync_q[SYNC_STAGES-1];
    end

    assign pair = {ss, sr};

    if (DEBOUNCE == 0) begin : g_nodeb
        assign filt_d = pair;
    end else begin : g_deb
        localparam int unsigned CW = $clog2(DEBOUNCE + 1);
        logic [CW-1:0] cnt_q, cnt_d;
        logic [1:0]    prev_q;

        // cnt_q counts consecutive identical samples of a pair that differs
        // from the filtered one; a change of pair restarts the run.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (pair == filt_q) begin
                cnt_d = '0;
            end else if (pair != prev_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q == CW'(DEBOUNCE)) begin
                filt_d = pair;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                prev_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                prev_q <= pair;
            end
        end
    end

    always_comb begin
        q_d   = sr_next_q(filt_q[1], filt_q[0], q_q, MODE);
        err_d = (&filt_q) | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            q_q    <= INIT;
            nq_q   <= ~INIT;
            err_q  <= 1'b0;
        end else begin
            filt_q <= filt_d;
            q_q    <= q_d;
            nq_q   <= ~q_d;
            err_q  <= err_d;
        end
    end

    assign q   = q_q;
    assign nq  = nq_q;
    assign err = err_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent clocked set/reset channels with synchronisers,
// optional debounce and selectable S=R=1 behaviour.
module sr_flop_bank
    import sr_flop_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 0,
    parameter logic [N-1:0] INIT       = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] s,
    input  logic [N-1:0] r,
    input  logic [N-1:0] err_clr,
    output logic [N-1:0] q,
    output logic [N-1:0] nq,
    output logic [N-1:0] err
);

    if (MODE > 3 || N < 1) begin : g_param_err
        $error("sr_flop_bank: MODE must be 0..3 and N >= 1");
    end

    localparam sr_mode_e MODE_E = sr_mode_e'(MODE[1:0]);

    for (genvar i = 0; i < N; i++) begin : g_chan
        sr_flop_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .MODE       (MODE_E),
            .INIT       (INIT[i])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .s      (s[i]),
            .r      (r[i]),
            .err_clr(err_clr[i]),
            .q      (q[i]),
            .nq     (nq[i]),
            .err    (err[i])
        );
    end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Scoreboard bench: several bank configurations driven by shared stimulus,
// each compared against a run-length behavioural model.
module tb_sr_flop_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_all = '1;
    logic [7:0] r_all = '0;
    logic [7:0] clr_all = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    localparam int NCFG = 5;

    // {N, MODE, SYNC_STAGES, DEBOUNCE, INIT}
    function automatic logic [31:0] cfg_word(input int idx);
        case (idx)
            0:       return {8'd4, 8'd0, 4'd2, 4'd0, 8'h05};
            1:       return {8'd8, 8'd1, 4'd2, 4'd3, 8'hA5};
            2:       return {8'd8, 8'd2, 4'd0, 4'd0, 8'h3C};
            3:       return {8'd8, 8'd3, 4'd1, 4'd2, 8'h00};
            default: return {8'd8, 8'd3, 4'd2, 4'd0, 8'hFF};
        endcase
    endfunction

    task automatic check(input int g, input string nm,
                         input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %02h expected %02h at %0t", g, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam logic [31:0] W = cfg_word(g);
        localparam int unsigned CN = 32'(W[31:24]);
        localparam int unsigned CM = 32'(W[23:16]);
        localparam int unsigned CS = 32'(W[15:12]);
        localparam int unsigned CD = 32'(W[11:8]);
        localparam logic [CN-1:0] CINIT = W[CN-1:0];

        logic [CN-1:0] q, nq, err;

        sr_flop_bank #(
            .N          (CN),
            .MODE       (CM),
            .SYNC_STAGES(CS),
            .DEBOUNCE   (CD),
            .INIT       (CINIT)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .s      (s_all[CN-1:0]),
            .r      (r_all[CN-1:0]),
            .err_clr(clr_all[CN-1:0]),
            .q      (q),
            .nq     (nq),
            .err    (err)
        );

        // Model state: input delay line, run length of the current synced
        // pair, accepted pair, stored q and err.
        logic [CN-1:0]     hs [$];
        logic [CN-1:0]     hr [$];
        int unsigned       run  [CN];
        logic [1:0]        last [CN];
        logic [1:0]        f    [CN];
        logic [CN-1:0]     mq, merr;
        logic [2*CN-1:0]   exp_fifo [$];

        task automatic mreset();
            hs.delete();
            hr.delete();
            for (int i = 0; i < int'(CS); i++) begin
                hs.push_back('0);
                hr.push_back('0);
            end
            for (int c = 0; c < int'(CN); c++) begin
                run[c]  = 0;
                last[c] = 2'b00;
                f[c]    = 2'b00;
            end
            mq   = CINIT;
            merr = '0;
        endtask

        initial begin : model
            logic [CN-1:0] ss, srv, nxq, nxe;
            logic [1:0]    p;
            mreset();
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    mreset();
                end else begin
                    if (CS == 0) begin
                        ss  = s_all[CN-1:0];
                        srv = r_all[CN-1:0];
                    end else begin
                        ss  = hs.pop_front();
                        srv = hr.pop_front();
                        hs.push_back(s_all[CN-1:0]);
                        hr.push_back(r_all[CN-1:0]);
                    end
                    for (int c = 0; c < int'(CN); c++) begin
                        case (f[c])
                            2'b10:   nxq[c] = 1'b1;
                            2'b01:   nxq[c] = 1'b0;
                            2'b11:   nxq[c] = (CM == 0) ? 1'b1 : (CM == 1) ? 1'b0 :
                                              (CM == 2) ? mq[c] : ~mq[c];
                            default: nxq[c] = mq[c];
                        endcase
                        nxe[c] = (f[c] == 2'b11) || (merr[c] && !clr_all[c]);
                        p = {ss[c], srv[c]};
                        if (p == last[c]) begin
                            run[c]++;
                        end else begin
                            run[c]  = 1;
                            last[c] = p;
                        end
                        if (p != f[c] && run[c] >= CD + 1) f[c] = p;
                    end
                    mq   = nxq;
                    merr = nxe;
                end
                exp_fifo.push_back({mq, merr});
            end
        end

        initial begin : monitor
            logic [2*CN-1:0] e;
            logic [CN-1:0]   enq;
            forever begin
                @(posedge clk);
                #2;
                if (exp_fifo.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cfg%0d scoreboard: got empty queue expected entry at %0t", g, $time);
                end else begin
                    e   = exp_fifo.pop_front();
                    enq = ~e[2*CN-1:CN];
                    check(g, "q",   8'(q),   8'(e[2*CN-1:CN]));
                    check(g, "nq",  8'(nq),  8'(enq));
                    check(g, "err", 8'(err), 8'(e[CN-1:0]));
                end
            end
        end

        always @(negedge rst_n) begin
            logic [CN-1:0] inq;
            #1;
            inq = ~CINIT;
            check(g, "rst_q",   8'(q),   8'(CINIT));
            check(g, "rst_nq",  8'(nq),  8'(inq));
            check(g, "rst_err", 8'(err), 8'h00);
        end
    end

    task automatic apply(input logic [7:0] sv, input logic [7:0] rv,
                         input logic [7:0] cv, input int unsigned cyc);
        s_all   = sv;
        r_all   = rv;
        clr_all = cv;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        s_all = '0;
        @(negedge clk);
        rst_n = 1'b1;

        apply(8'h01, 8'h00, 8'h00, 1);
        apply(8'h00, 8'h00, 8'h00, 8);
        apply(8'h00, 8'h01, 8'h00, 1);
        apply(8'h00, 8'h00, 8'h00, 8);
        apply(8'h02, 8'h02, 8'h00, 8);
        apply(8'h00, 8'h00, 8'h00, 6);
        apply(8'h00, 8'h00, 8'h02, 1);
        apply(8'h00, 8'h00, 8'h00, 3);
        apply(8'h04, 8'h00, 8'h00, 2);
        apply(8'h00, 8'h00, 8'h00, 8);
        apply(8'h04, 8'h00, 8'h00, 5);
        apply(8'h00, 8'h00, 8'h00, 8);
        apply(8'h0E, 8'h0A, 8'h00, 6);
        rst_n = 1'b0;
        apply(8'h0E, 8'h0A, 8'h00, 2);
        rst_n = 1'b1;
        apply(8'h0E, 8'h0A, 8'h00, 12);

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(4) == 0) begin
                    s_all[c] = 1'($urandom_range(1));
                    r_all[c] = 1'($urandom_range(1));
                end
                clr_all[c] = ($urandom_range(7) == 0);
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(599) == 0) rst_n = 1'b0;
            @(negedge clk);
        end

        rst_n = 1'b1;
        apply(8'h00, 8'h00, 8'h00, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
